aib_io_remap_table: RTL and testbench

//  Run-time programmable lane<->bump remapper; successor to the fixed-table AIB channel I/O mapping.

---
 rtl/aib_io_remap_table.sv | 214 +++++++++++++++++++++
 tb/tb_aib_io_remap_table.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_io_remap_table.sv
// Run-time programmable lane<->pad remapper for an AIB channel.
// Software fills a shadow table; a commit scans it for range/collision errors and swaps it in atomically.
module aib_io_remap_table #(
  parameter  int NumIo    = 96,
  parameter  int NumLanes = 20,
  localparam int IdxW     = $clog2(NumIo),
  localparam int LaneW    = $clog2(NumLanes)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic                i_cfg_dir,
  input  logic [LaneW-1:0]    i_cfg_lane,
  input  logic [IdxW-1:0]     i_cfg_pad,
  input  logic                i_cfg_en,
  input  logic                i_cfg_commit,
  output logic                o_busy,
  output logic                o_map_err,
  output logic                o_map_active,
  input  logic [NumLanes-1:0] i_tx_data0,
  input  logic [NumLanes-1:0] i_tx_data1,
  output logic [NumIo-1:0]    o_iob_tx_en,
  output logic [NumIo-1:0]    o_iob_tx_data0,
  output logic [NumIo-1:0]    o_iob_tx_data1,
  input  logic [NumIo-1:0]    i_iob_rx_data0,
  input  logic [NumIo-1:0]    i_iob_rx_data1,
  output logic [NumLanes-1:0] o_rx_data0,
  output logic [NumLanes-1:0] o_rx_data1
);

  localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);
  localparam logic [IdxW-1:0]  MaxPad   = IdxW'(NumIo - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_SWAP} state_e;

  typedef struct packed {
    logic            en;
    logic [IdxW-1:0] pad;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           sh_tx_q [NumLanes];
  entry_t           sh_tx_d [NumLanes];
  entry_t           sh_rx_q [NumLanes];
  entry_t           sh_rx_d [NumLanes];
  entry_t           act_tx_q [NumLanes];
  entry_t           act_tx_d [NumLanes];
  entry_t           act_rx_q [NumLanes];
  entry_t           act_rx_d [NumLanes];
  logic [LaneW-1:0] lane_q, lane_d;
  logic [NumIo-1:0] used_q, used_d;
  logic             chk_err_q, chk_err_d;
  logic             map_err_q, map_err_d;
  logic             map_active_q, map_active_d;

  logic [NumIo-1:0]    tx_en_q, tx_en_d;
  logic [NumIo-1:0]    tx_d0_q, tx_d0_d;
  logic [NumIo-1:0]    tx_d1_q, tx_d1_d;
  logic [NumLanes-1:0] rx_d0_q, rx_d0_d;
  logic [NumLanes-1:0] rx_d1_q, rx_d1_d;

  entry_t cur_tx, cur_rx;
  logic   lane_err;
  logic   cfg_acc;

  assign o_cfg_ready = (state_q == ST_IDLE) & ~i_rst;
  assign o_busy      = (state_q != ST_IDLE);
  assign cfg_acc     = i_cfg_valid & o_cfg_ready;
  assign cur_tx      = sh_tx_q[lane_q];
  assign cur_rx      = sh_rx_q[lane_q];

  always_comb begin
    state_d      = state_q;
    sh_tx_d      = sh_tx_q;
    sh_rx_d      = sh_rx_q;
    act_tx_d     = act_tx_q;
    act_rx_d     = act_rx_q;
    lane_d       = lane_q;
    used_d       = used_q;
    chk_err_d    = chk_err_q;
    map_err_d    = map_err_q;
    map_active_d = map_active_q;
    lane_err     = 1'b0;

    // The write is applied before the commit is evaluated, so a same-cycle commit checks it.
    if (cfg_acc) begin
      if (i_cfg_lane > LastLane) begin
        map_err_d = 1'b1;
      end else if (i_cfg_dir) begin
        sh_rx_d[i_cfg_lane] = '{en: i_cfg_en, pad: i_cfg_pad};
      end else begin
        sh_tx_d[i_cfg_lane] = '{en: i_cfg_en, pad: i_cfg_pad};
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_commit) begin
          state_d   = ST_CHECK;
          map_err_d = 1'b0;
          used_d    = '0;
          lane_d    = '0;
          chk_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        // RX is tested against the bitmap as it was before this lane; the TX==RX case is caught directly.
        if (cur_tx.en) begin
          if (cur_tx.pad > MaxPad) begin
            lane_err = 1'b1;
          end else begin
            if (used_q[cur_tx.pad]) lane_err = 1'b1;
            used_d[cur_tx.pad] = 1'b1;
          end
        end
        if (cur_rx.en) begin
          if (cur_rx.pad > MaxPad) begin
            lane_err = 1'b1;
          end else begin
            if (used_q[cur_rx.pad]) lane_err = 1'b1;
            used_d[cur_rx.pad] = 1'b1;
          end
        end
        if (cur_tx.en && cur_rx.en && (cur_tx.pad == cur_rx.pad)) lane_err = 1'b1;
        chk_err_d = chk_err_q | lane_err;
        if (lane_q == LastLane) begin
          if (chk_err_d) begin
            state_d   = ST_IDLE;
            map_err_d = 1'b1;
          end else begin
            state_d = ST_SWAP;
          end
        end else begin
          lane_d = lane_q + LaneW'(1);
        end
      end
      ST_SWAP: begin
        act_tx_d     = sh_tx_q;
        act_rx_d     = sh_rx_q;
        map_active_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath uses only the active table, so a swap changes every lane in the same cycle.
  always_comb begin
    tx_en_d = '0;
    tx_d0_d = '0;
    tx_d1_d = '0;
    rx_d0_d = '0;
    rx_d1_d = '0;
    for (int l = 0; l < NumLanes; l++) begin
      if (act_tx_q[l].en && (act_tx_q[l].pad <= MaxPad)) begin
        tx_en_d[act_tx_q[l].pad] = 1'b1;
        tx_d0_d[act_tx_q[l].pad] = i_tx_data0[l];
        tx_d1_d[act_tx_q[l].pad] = i_tx_data1[l];
      end
      if (act_rx_q[l].en && (act_rx_q[l].pad <= MaxPad)) begin
        rx_d0_d[l] = i_iob_rx_data0[act_rx_q[l].pad];
        rx_d1_d[l] = i_iob_rx_data1[act_rx_q[l].pad];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      used_q       <= '0;
      chk_err_q    <= 1'b0;
      map_err_q    <= 1'b0;
      map_active_q <= 1'b0;
      tx_en_q      <= '0;
      tx_d0_q      <= '0;
      tx_d1_q      <= '0;
      rx_d0_q      <= '0;
      rx_d1_q      <= '0;
      for (int l = 0; l < NumLanes; l++) begin
        sh_tx_q[l]  <= '0;
        sh_rx_q[l]  <= '0;
        act_tx_q[l] <= '0;
        act_rx_q[l] <= '0;
      end
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      used_q       <= used_d;
      chk_err_q    <= chk_err_d;
      map_err_q    <= map_err_d;
      map_active_q <= map_active_d;
      tx_en_q      <= tx_en_d;
      tx_d0_q      <= tx_d0_d;
      tx_d1_q      <= tx_d1_d;
      rx_d0_q      <= rx_d0_d;
      rx_d1_q      <= rx_d1_d;
      sh_tx_q      <= sh_tx_d;
      sh_rx_q      <= sh_rx_d;
      act_tx_q     <= act_tx_d;
      act_rx_q     <= act_rx_d;
    end
  end

  assign o_map_err      = map_err_q;
  assign o_map_active   = map_active_q;
  assign o_iob_tx_en    = tx_en_q;
  assign o_iob_tx_data0 = tx_d0_q;
  assign o_iob_tx_data1 = tx_d1_q;
  assign o_rx_data0     = rx_d0_q;
  assign o_rx_data1     = rx_d1_q;

endmodule

// File: tb/tb_aib_io_remap_table.sv
// Directed + randomized bench for aib_io_remap_table against a table-level reference model.
module tb_aib_io_remap_table;
  localparam int NumIo    = 96;
  localparam int NumLanes = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_dir, cfg_en, cfg_commit;
  logic [4:0]  cfg_lane;
  logic [6:0]  cfg_pad;
  logic        busy, map_err, map_active;
  logic [19:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic [95:0] iob_tx_en, iob_tx_data0, iob_tx_data1, iob_rx_data0, iob_rx_data1;

  always #5 clk = ~clk;

  aib_io_remap_table dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_dir(cfg_dir),
    .i_cfg_lane(cfg_lane), .i_cfg_pad(cfg_pad), .i_cfg_en(cfg_en), .i_cfg_commit(cfg_commit),
    .o_busy(busy), .o_map_err(map_err), .o_map_active(map_active),
    .i_tx_data0(tx_data0), .i_tx_data1(tx_data1),
    .o_iob_tx_en(iob_tx_en), .o_iob_tx_data0(iob_tx_data0), .o_iob_tx_data1(iob_tx_data1),
    .i_iob_rx_data0(iob_rx_data0), .i_iob_rx_data1(iob_rx_data1),
    .o_rx_data0(rx_data0), .o_rx_data1(rx_data1)
  );

  // Reference model: [0]=TX, [1]=RX; shadow and active tables as plain arrays.
  bit m_sh_en [2][NumLanes];
  int m_sh_pad[2][NumLanes];
  bit m_ac_en [2][NumLanes];
  int m_ac_pad[2][NumLanes];
  bit m_err, m_active;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NumLanes; l++) begin
        m_sh_en[d][l] = 0; m_sh_pad[d][l] = 0;
        m_ac_en[d][l] = 0; m_ac_pad[d][l] = 0;
      end
    m_err = 0;
    m_active = 0;
  endtask

  // A table is legal when every enabled pad is in range and no pad is claimed twice.
  function automatic bit model_bad();
    int cnt[NumIo];
    bit bad = 0;
    foreach (cnt[p]) cnt[p] = 0;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NumLanes; l++)
        if (m_sh_en[d][l]) begin
          if (m_sh_pad[d][l] >= NumIo) bad = 1;
          else cnt[m_sh_pad[d][l]]++;
        end
    foreach (cnt[p]) if (cnt[p] > 1) bad = 1;
    return bad;
  endfunction

  task automatic model_write(input int dir, input int lane, input int pad, input bit en);
    if (lane >= NumLanes) m_err = 1;
    else begin
      m_sh_en[dir][lane]  = en;
      m_sh_pad[dir][lane] = pad;
    end
  endtask

  task automatic cfg_wr(input int dir, input int lane, input int pad, input bit en);
    cfg_valid = 1; cfg_dir = dir[0]; cfg_lane = 5'(lane); cfg_pad = 7'(pad); cfg_en = en;
    chk("cfg_ready_idle", 128'(cfg_ready), 128'(1));
    tick();
    cfg_valid = 0;
    model_write(dir, lane, pad, en);
  endtask

  task automatic model_commit();
    m_err = model_bad();
    if (!m_err) begin
      m_ac_en  = m_sh_en;
      m_ac_pad = m_sh_pad;
      m_active = 1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk(tag, 128'(n), 128'(m_err ? NumLanes : NumLanes + 1));
    chk("map_err", 128'(map_err), 128'(m_err));
    chk("map_active", 128'(map_active), 128'(m_active));
  endtask

  task automatic commit(input string tag);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    model_commit();
    wait_idle(tag);
  endtask

  task automatic dp_check(input int iters, input bit directed);
    logic [95:0] e_en, e_d0, e_d1;
    logic [19:0] e_r0, e_r1;
    for (int i = 0; i < iters; i++) begin
      tx_data0 = 20'($urandom); tx_data1 = 20'($urandom);
      iob_rx_data0 = {$urandom, $urandom, $urandom};
      iob_rx_data1 = {$urandom, $urandom, $urandom};
      if (directed && i == 0) begin
        tx_data0 = 20'hA5A5A;
        iob_rx_data0[39:20] = 20'h12345;
      end
      e_en = '0; e_d0 = '0; e_d1 = '0; e_r0 = '0; e_r1 = '0;
      for (int p = 0; p < NumIo; p++)
        for (int l = 0; l < NumLanes; l++)
          if (m_ac_en[0][l] && m_ac_pad[0][l] == p) begin
            e_en[p] = 1; e_d0[p] = tx_data0[l]; e_d1[p] = tx_data1[l];
          end
      for (int l = 0; l < NumLanes; l++)
        if (m_ac_en[1][l]) begin
          e_r0[l] = iob_rx_data0[m_ac_pad[1][l]];
          e_r1[l] = iob_rx_data1[m_ac_pad[1][l]];
        end
      tick();
      chk("tx_en", 128'(iob_tx_en), 128'(e_en));
      chk("tx_data0", 128'(iob_tx_data0), 128'(e_d0));
      chk("tx_data1", 128'(iob_tx_data1), 128'(e_d1));
      chk("rx_data0", 128'(rx_data0), 128'(e_r0));
      chk("rx_data1", 128'(rx_data1), 128'(e_r1));
    end
  endtask

  task automatic load_identity();
    for (int l = 0; l < NumLanes; l++) begin
      cfg_wr(0, l, l, 1);
      cfg_wr(1, l, 20 + l, 1);
    end
  endtask

  initial begin
    int perm[NumIo];
    int n;
    rst = 1; cfg_valid = 0; cfg_dir = 0; cfg_lane = 0; cfg_pad = 0; cfg_en = 0; cfg_commit = 0;
    tx_data0 = 0; tx_data1 = 0; iob_rx_data0 = 0; iob_rx_data1 = 0;
    model_reset();

    // 1: reset
    tick(); tick();
    chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tx_en", 128'(iob_tx_en), 128'(0));
    chk("rst_map_active", 128'(map_active), 128'(0));
    rst = 0;
    #1;
    chk("post_rst_cfg_ready", 128'(cfg_ready), 128'(1));
    dp_check(2, 0);

    // 2: identity map
    load_identity();
    commit("busy_identity");
    dp_check(4, 1);

    // 3: duplicate TX pad, prior map kept
    cfg_wr(0, 3, 52, 1);
    cfg_wr(0, 7, 52, 1);
    commit("busy_dup");
    dp_check(2, 0);

    // 4: range error, TX/RX collision, bad lane, then clean commit
    cfg_wr(0, 3, 3, 1);
    cfg_wr(0, 7, 7, 1);
    cfg_wr(0, 0, 96, 1);
    commit("busy_range");
    cfg_wr(0, 0, 0, 1);
    cfg_wr(0, 5, 60, 1);
    cfg_wr(1, 5, 60, 1);
    commit("busy_collide");
    cfg_wr(0, 5, 5, 1);
    cfg_wr(1, 5, 25, 1);
    cfg_wr(1, 25, 3, 1);
    chk("bad_lane_err", 128'(map_err), 128'(m_err));
    cfg_wr(1, 6, 90, 1);
    cfg_wr(0, 9, 0, 0);
    commit("busy_clean");
    dp_check(3, 0);

    // 5: races - write and second commit during CHECK are ignored
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    model_commit();
    n = 0;
    while (busy && n < 40) begin
      if (n == 2) begin
        cfg_valid = 1; cfg_dir = 0; cfg_lane = 1; cfg_pad = 7'd96; cfg_en = 1;
        chk("cfg_ready_check", 128'(cfg_ready), 128'(0));
      end
      if (n == 3) cfg_valid = 0;
      cfg_commit = (n == 5);
      n++;
      tick();
    end
    cfg_valid = 0; cfg_commit = 0;
    chk("busy_race", 128'(n), 128'(m_err ? NumLanes : NumLanes + 1));
    chk("race_map_err", 128'(map_err), 128'(m_err));
    tick();
    chk("race_no_recommit", 128'(busy), 128'(0));
    dp_check(2, 0);

    // write + commit in the same cycle: the new entry is checked
    cfg_valid = 1; cfg_dir = 1; cfg_lane = 2; cfg_pad = 7'd99; cfg_en = 1; cfg_commit = 1;
    tick();
    cfg_valid = 0; cfg_commit = 0;
    model_write(1, 2, 99, 1);
    model_commit();
    wait_idle("busy_same_cycle");
    cfg_wr(1, 2, 22, 1);

    // randomized maps: even rounds are permutations, odd rounds free-for-all
    for (int r = 0; r < 6; r++) begin
      foreach (perm[p]) perm[p] = p;
      for (int p = NumIo - 1; p > 0; p--) begin
        int j = $urandom_range(p, 0);
        int t = perm[p];
        perm[p] = perm[j]; perm[j] = t;
      end
      for (int l = 0; l < NumLanes; l++) begin
        if (r % 2 == 0) begin
          cfg_wr(0, l, perm[l], ($urandom_range(4, 0) != 0));
          cfg_wr(1, l, perm[NumLanes + l], ($urandom_range(4, 0) != 0));
        end else begin
          cfg_wr(0, l, $urandom_range(100, 0), 1);
          cfg_wr(1, l, $urandom_range(100, 0), 1);
        end
      end
      commit("busy_random");
      dp_check(3, 0);
    end

    // 6: reset at CHECK cycle 10
    load_identity();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_check_busy", 128'(busy), 128'(1));
    rst = 1;
    tick();
    model_reset();
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_tx_en", 128'(iob_tx_en), 128'(0));
    chk("midrst_map_active", 128'(map_active), 128'(0));
    rst = 0;
    dp_check(2, 0);
    commit("busy_empty_table");
    dp_check(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
